nibble_serial_adder_ctrl: RTL and testbench

Sequencing controller that performs a 4·NIBBLES-bit addition over NIBBLES clock cycles by time-multiplexing the team's combinational 4-bit ripple-carry adder. Each cycle it drives one operand nibble pair plus the stored carry into the adder, then captures the nibble sum and carry-out. It sits on both sides of that adder: upstream, feeding a/b/c_in; downstream, registering sum/c_out. It presents a start/done handshake to the datapath above.

---
 rtl/nibble_serial_adder_ctrl.sv | 126 ++++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
// Performs a 4*NIBBLES-bit addition over NIBBLES cycles by feeding one
// nibble pair per cycle through an external 4-bit ripple-carry adder and
// collecting the nibble sums into an accumulator. A start/done handshake
// faces the datapath above; busy marks the cycles the adder is in use.

module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic                   cin,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
  output logic                   overflow,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_sum,
  input  logic                   add_cout
);

  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  logic [W-1:0]    a_sh;
  logic [W-1:0]    b_sh;
  logic [W-1:0]    acc;
  logic [W-1:0]    acc_next;
  logic            carry_r;
  logic [IDXW-1:0] idx;
  logic            a_msb;
  logic            b_msb;

  // The incoming nibble sum enters at the top of the accumulator; written
  // as shift-and-merge so it stays valid when there is only one nibble.
  always_comb begin
    acc_next = (acc >> 4) | (W'(add_sum) << (W - 4));
  end

  // Adder operands come straight from registers and are zeroed outside RUN
  // so the shared adder sees quiet inputs when this block is not using it.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_sh[3:0];
      add_b   = b_sh[3:0];
      add_cin = carry_r;
    end
  end

  // Sequencer: accepts operands, steps one nibble per cycle, then holds the
  // registered result and pulses done for a single cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      carry_r  <= 1'b0;
      acc      <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      idx      <= '0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh    <= op_a;
            b_sh    <= op_b;
            carry_r <= cin;
            idx     <= '0;
            a_msb   <= op_a[W-1];
            b_msb   <= op_b[W-1];
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          acc     <= acc_next;
          carry_r <= add_cout;
          a_sh    <= a_sh >> 4;
          b_sh    <= b_sh >> 4;
          idx     <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            result   <= acc_next;
            cout     <= add_cout;
            overflow <= (a_msb == b_msb) && (add_sum[3] != a_msb);
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl
// Wraps the controller with a 4-bit ripple-carry adder and runs directed
// additions with hand-computed results, checking the nibble feed each cycle.

module tb_nibble_serial_adder_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        cout;
  logic        overflow;
  logic [3:0]  add_a;
  logic [3:0]  add_b;
  logic        add_cin;
  logic [3:0]  add_sum;
  logic        add_cout;

  int          checks;
  int          errors;
  logic [15:0] last_result;
  logic        last_cout;
  logic        last_ovf;

  nibble_serial_adder_ctrl #(.NIBBLES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  // Ripple-carry adder slice shared with the controller
  logic [4:0] c;
  always_comb begin
    c[0] = add_cin;
    for (int k = 0; k < 4; k++) begin
      add_sum[k] = add_a[k] ^ add_b[k] ^ c[k];
      c[k+1]     = (add_a[k] & add_b[k]) | (c[k] & (add_a[k] ^ add_b[k]));
    end
    add_cout = c[4];
  end

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkIdle();
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_done", 32'(done), 32'd0);
    checkOutput("idle_add_a", 32'(add_a), 32'd0);
    checkOutput("idle_add_b", 32'(add_b), 32'd0);
    checkOutput("idle_add_cin", 32'(add_cin), 32'd0);
    checkOutput("idle_result", 32'(result), 32'(last_result));
  endtask

  // Called at a negedge in IDLE or DONE; returns at the DONE-cycle negedge.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic ci,
                               input logic [15:0] exp_r, input logic exp_c, input logic exp_o,
                               input bit noise);
    logic [15:0] mask;
    logic [16:0] part;
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    cin   = ci;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mask = 16'((17'd1 << (4 * i)) - 17'd1);
      part = {1'b0, a & mask} + {1'b0, b & mask} + 17'(ci);
      checkOutput("run_busy", 32'(busy), 32'd1);
      checkOutput("run_done", 32'(done), 32'd0);
      checkOutput("run_add_a", 32'(add_a), 32'((a >> (4 * i)) & 16'hF));
      checkOutput("run_add_b", 32'(add_b), 32'((b >> (4 * i)) & 16'hF));
      checkOutput("run_add_cin", 32'(add_cin), 32'(part[4 * i]));
      checkOutput("run_result_hold", 32'(result), 32'(last_result));
      checkOutput("run_cout_hold", 32'(cout), 32'(last_cout));
      checkOutput("run_ovf_hold", 32'(overflow), 32'(last_ovf));
      if (noise) begin
        start = (i == 1 || i == 2);
        op_a  = 16'hAAAA;
        op_b  = 16'h5555;
        cin   = 1'b1;
      end
      @(negedge clk);
    end
    checkOutput("done_pulse", 32'(done), 32'd1);
    checkOutput("done_busy", 32'(busy), 32'd0);
    checkOutput("done_result", 32'(result), 32'(exp_r));
    checkOutput("done_cout", 32'(cout), 32'(exp_c));
    checkOutput("done_overflow", 32'(overflow), 32'(exp_o));
    checkOutput("done_add_a", 32'(add_a), 32'd0);
    checkOutput("done_add_b", 32'(add_b), 32'd0);
    checkOutput("done_add_cin", 32'(add_cin), 32'd0);
    last_result = exp_r;
    last_cout   = exp_c;
    last_ovf    = exp_o;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    last_result = 16'h0;
    last_cout   = 1'b0;
    last_ovf    = 1'b0;
    rst   = 1'b1;
    start = 1'b0;
    op_a  = 16'h0;
    op_b  = 16'h0;
    cin   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_result", 32'(result), 32'd0);
    checkOutput("reset_cout", 32'(cout), 32'd0);
    checkOutput("reset_overflow", 32'(overflow), 32'd0);
    checkIdle();
    rst = 1'b0;
    @(negedge clk);
    checkIdle();

    applyStimulus(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkIdle();
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(16'h00FF, 16'h0F00, 1'b1, 16'h1000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // start pulsed with other operands while running must be ignored
    applyStimulus(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkIdle();

    // back-to-back: second accept taken in the DONE cycle
    applyStimulus(16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkIdle();

    // asynchronous reset after two nibbles have been captured
    start = 1'b1;
    op_a  = 16'h1234;
    op_b  = 16'h1111;
    cin   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("mid_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    last_result = 16'h0;
    last_cout   = 1'b0;
    last_ovf    = 1'b0;
    checkOutput("arst_result", 32'(result), 32'd0);
    checkOutput("arst_cout", 32'(cout), 32'd0);
    checkOutput("arst_overflow", 32'(overflow), 32'd0);
    checkIdle();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkIdle();
    applyStimulus(16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkIdle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
